// File: rtl/collision_flag_reader.sv
// Once per frame, runs the collision analyzer, captures its flag bus and serves the
// snapshot to the processor over a request/ack read port with clear-on-read and irq.
module collision_flag_reader #(
  parameter int FLAG_WIDTH     = 30,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit CLEAR_ON_READ  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  analyze_done,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  output logic                  analyze_enable,
  input  logic                  rd_req,
  input  logic [1:0]            rd_addr,
  output logic [15:0]           rd_data,
  output logic                  rd_ack,
  output logic                  irq
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t                state;
  logic [FLAG_WIDTH-1:0] flags_q, snapshot, snap_nxt, clr_mask;
  logic                  valid, overrun, timeout;
  logic [15:0]           frame_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [31:0]           snap_pad;
  logic [15:0]           status, rd_word;
  logic                  rd_fire, clr_lo, clr_hi, clr_stat, capture, tmo_hit;

  assign rd_fire  = rd_req && !rd_ack;
  assign clr_lo   = CLEAR_ON_READ && rd_fire && (rd_addr == 2'd0);
  assign clr_hi   = CLEAR_ON_READ && rd_fire && (rd_addr == 2'd1);
  assign clr_stat = CLEAR_ON_READ && rd_fire && (rd_addr == 2'd2);
  assign capture  = (state == CAPTURE);
  assign tmo_hit  = (state == RUN) && !analyze_done && (tmo_cnt == TMO_LAST);

  always_comb begin
    snap_pad = '0;
    snap_pad[FLAG_WIDTH-1:0] = snapshot;
    status = {12'h000, state != IDLE, timeout, overrun, valid};
    case (rd_addr)
      2'd0:    rd_word = snap_pad[15:0];
      2'd1:    rd_word = snap_pad[31:16];
      2'd2:    rd_word = status;
      default: rd_word = frame_cnt;
    endcase
    for (int i = 0; i < FLAG_WIDTH; i++)
      clr_mask[i] = (i < 16) ? clr_lo : clr_hi;
    // A capture in the same cycle as a clearing read keeps the fresh snapshot.
    snap_nxt = capture ? flags_q : (snapshot & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      analyze_enable <= 1'b0;
      flags_q        <= '0;
      snapshot       <= '0;
      valid          <= 1'b0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
      frame_cnt      <= '0;
      tmo_cnt        <= '0;
      rd_data        <= '0;
      rd_ack         <= 1'b0;
      irq            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (frame_start) begin
            state          <= RUN;
            analyze_enable <= 1'b1;
          end
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (analyze_done) begin
            state          <= CAPTURE;
            analyze_enable <= 1'b0;
            flags_q        <= flags_in;
          end else if (tmo_hit) begin
            state          <= IDLE;
            analyze_enable <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          analyze_enable <= 1'b0;
          tmo_cnt        <= '0;
          frame_cnt      <= frame_cnt + 1'b1;
        end
      endcase

      snapshot <= snap_nxt;
      irq      <= |snap_nxt;

      // Setting events take priority over a clearing status read.
      if (capture)       valid <= 1'b1;
      else if (clr_stat) valid <= 1'b0;
      if (frame_start && state != IDLE) overrun <= 1'b1;
      else if (clr_stat)                overrun <= 1'b0;
      if (tmo_hit)       timeout <= 1'b1;
      else if (clr_stat) timeout <= 1'b0;

      rd_ack <= rd_fire;
      if (rd_fire) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_collision_flag_reader.sv
// Directed bench: DUT 0 uses the default timeout, DUT 1 a 16-cycle timeout.
// Read responses are checked by a scoreboard monitor on the falling edge.
module tb_collision_flag_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs    [2];
  logic        done  [2];
  logic [29:0] flags [2];
  logic        en    [2];
  logic        req   [2];
  logic [1:0]  addr  [2];
  logic [15:0] data  [2];
  logic        ack   [2];
  logic        irq   [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  collision_flag_reader #(.FLAG_WIDTH(30), .TIMEOUT_CYCLES(4096), .CLEAR_ON_READ(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .frame_start(fs[0]), .analyze_done(done[0]), .flags_in(flags[0]),
    .analyze_enable(en[0]), .rd_req(req[0]), .rd_addr(addr[0]), .rd_data(data[0]),
    .rd_ack(ack[0]), .irq(irq[0]));

  collision_flag_reader #(.FLAG_WIDTH(30), .TIMEOUT_CYCLES(16), .CLEAR_ON_READ(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .frame_start(fs[1]), .analyze_done(done[1]), .flags_in(flags[1]),
    .analyze_enable(en[1]), .rd_req(req[1]), .rd_addr(addr[1]), .rd_data(data[1]),
    .rd_ack(ack[1]), .irq(irq[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops the oldest expected read word.
  always @(negedge clk) begin
    if (ack[0]) begin
      if (q0.size() == 0) check("dut0 unexpected ack", 32'd1, 32'd0);
      else check("dut0 rd_data", {16'h0, data[0]}, {16'h0, q0.pop_front()});
    end
    if (ack[1]) begin
      if (q1.size() == 0) check("dut1 unexpected ack", 32'd1, 32'd0);
      else check("dut1 rd_data", {16'h0, data[1]}, {16'h0, q1.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int d, input logic [1:0] a, input logic [15:0] exp);
    if (d == 0) q0.push_back(exp); else q1.push_back(exp);
    req[d] = 1'b1; addr[d] = a;
    tick(1);
    req[d] = 1'b0;
    tick(1);
  endtask

  task automatic pulse_fs(input int d);
    fs[d] = 1'b1;
    tick(1);
    fs[d] = 1'b0;
  endtask

  task automatic pulse_done(input int d, input logic [29:0] f);
    done[d] = 1'b1; flags[d] = f;
    tick(1);
    done[d] = 1'b0; flags[d] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fs[d] = 1'b0; done[d] = 1'b0; flags[d] = '0; req[d] = 1'b0; addr[d] = '0;
    end
    tick(3);
    check("reset en",   {31'h0, en[0]},   32'd0);
    check("reset ack",  {31'h0, ack[0]},  32'd0);
    check("reset data", {16'h0, data[0]}, 32'd0);
    check("reset irq",  {31'h0, irq[0]},  32'd0);
    reset = 1'b1;
    tick(1);
    do_read(0, 2'd2, 16'h0000);

    // Normal frame: done arrives 20 cycles after frame_start
    pulse_fs(0);
    check("en after frame_start", {31'h0, en[0]}, 32'd1);
    tick(18);
    check("en during run", {31'h0, en[0]}, 32'd1);
    tick(1);
    pulse_done(0, 30'h2000_0005);
    check("en in capture", {31'h0, en[0]}, 32'd0);
    check("irq before snapshot", {31'h0, irq[0]}, 32'd0);
    tick(1);
    check("irq after capture", {31'h0, irq[0]}, 32'd1);
    do_read(0, 2'd3, 16'h0001);
    do_read(0, 2'd2, 16'h0001);
    do_read(0, 2'd0, 16'h0005);
    check("irq after low clear", {31'h0, irq[0]}, 32'd1);
    do_read(0, 2'd1, 16'h2000);
    check("irq after high clear", {31'h0, irq[0]}, 32'd0);
    do_read(0, 2'd0, 16'h0000);

    // Overrun: second frame_start 5 cycles into RUN is ignored
    pulse_fs(0);
    tick(4);
    pulse_fs(0);
    check("en overrun run", {31'h0, en[0]}, 32'd1);
    pulse_done(0, 30'h0001_0044);
    tick(4);
    check("en single analysis", {31'h0, en[0]}, 32'd0);
    do_read(0, 2'd2, 16'h0003);
    do_read(0, 2'd3, 16'h0002);

    // Clearing read of addr 0 coincides with capture of 0x3
    pulse_fs(0);
    tick(2);
    pulse_done(0, 30'h0000_0003);
    q0.push_back(16'h0044);
    req[0] = 1'b1; addr[0] = 2'd0;
    tick(1);
    req[0] = 1'b0;
    tick(1);
    check("irq after coincident clear", {31'h0, irq[0]}, 32'd1);
    do_read(0, 2'd0, 16'h0003);
    check("irq after clearing new snap", {31'h0, irq[0]}, 32'd0);
    do_read(0, 2'd2, 16'h0001);
    do_read(0, 2'd3, 16'h0003);

    // Timeout on the 16-cycle instance, after one good frame
    pulse_fs(1);
    tick(3);
    pulse_done(1, 30'h0000_1234);
    tick(1);
    check("dut1 irq", {31'h0, irq[1]}, 32'd1);
    do_read(1, 2'd2, 16'h0001);
    do_read(1, 2'd3, 16'h0001);
    pulse_fs(1);
    check("dut1 en start", {31'h0, en[1]}, 32'd1);
    tick(15);
    check("dut1 en last run cycle", {31'h0, en[1]}, 32'd1);
    tick(1);
    check("dut1 en after timeout", {31'h0, en[1]}, 32'd0);
    do_read(1, 2'd2, 16'h0004);
    do_read(1, 2'd3, 16'h0001);
    check("dut1 irq kept", {31'h0, irq[1]}, 32'd1);
    do_read(1, 2'd0, 16'h1234);

    // Reset in the middle of RUN
    pulse_fs(0);
    tick(3);
    check("en before mid reset", {31'h0, en[0]}, 32'd1);
    reset = 1'b0;
    tick(1);
    check("mid reset en",   {31'h0, en[0]},   32'd0);
    check("mid reset data", {16'h0, data[0]}, 32'd0);
    check("mid reset ack",  {31'h0, ack[0]},  32'd0);
    check("mid reset irq",  {31'h0, irq[0]},  32'd0);
    reset = 1'b1;
    tick(1);
    do_read(0, 2'd2, 16'h0000);
    do_read(0, 2'd3, 16'h0000);

    tick(3);
    check("dut0 pending reads", q0.size(), 32'd0);
    check("dut1 pending reads", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_flag_reader.md
Name: collision_flag_reader

Overview:
- Consumer end of the collision analysis interface. Once per frame it starts the analyzer, waits for completion, takes a snapshot of the 30-bit collision flag bus, and serves the snapshot to the processor.
- Processor access uses a word-addressed request/acknowledge handshake, with optional clear-on-read and a level interrupt.
- Sits between the collision analyzer and the processor-facing register/bus bridge.

Parameters:
- FLAG_WIDTH, 30, width of the collision flag bus.
- TIMEOUT_CYCLES, 4096, max cycles to wait for analyzer completion before aborting.
- CLEAR_ON_READ, 1, 1 = reading a flag word clears its snapshot bits and the sticky status bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- frame_start  input  1  one-cycle pulse per frame (vsync); requests a new analysis.
- analyze_done  input  1  one-cycle pulse from the analyzer; analysis complete, flags valid.
- flags_in  input  FLAG_WIDTH  collision flags from the analyzer.
- analyze_enable  output  1  held high while an analysis is in progress (drives the analyzer enable).
- rd_req  input  1  processor read request (level).
- rd_addr  input  2  0 = flags[15:0]; 1 = {2'b0, flags[29:16]}; 2 = status; 3 = frame counter.
- rd_data  output  16  read data, valid when rd_ack = 1.
- rd_ack  output  1  one-cycle read acknowledge.
- irq  output  1  high while the snapshot holds any nonzero bit.

Behaviour:
- Reset (reset = 0 at a clk edge): FSM to IDLE; analyze_enable = 0; snapshot = 0; status = 0; frame counter = 0; timeout counter = 0; rd_data = 0; rd_ack = 0; irq = 0. Reset mid-analysis aborts silently, with no overrun or timeout recorded.
- FSM states: IDLE, RUN, CAPTURE.
- IDLE:
  - frame_start = 1 -> RUN; analyze_enable = 1 from the next cycle.
  - Timeout counter clears.
- RUN:
  - analyze_enable = 1; timeout counter increments each cycle.
  - analyze_done = 1 -> CAPTURE and register flags_in that cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without done -> IDLE; set status.timeout; snapshot unchanged.
  - frame_start during RUN is ignored and sets status.overrun (sticky).
  - If done and timeout occur in the same cycle, done wins.
- CAPTURE (one cycle):
  - analyze_enable = 0.
  - snapshot <= registered flags (replaces; no OR accumulation).
  - frame counter +1 (16-bit, wraps 0xFFFF -> 0).
  - status.valid <= 1.
  - -> IDLE.
  - A frame_start coincident with CAPTURE sets overrun and is dropped.
- Latency: frame_start to analyze_enable high is 1 cycle; analyze_done to snapshot update is 2 cycles; snapshot update to irq is same cycle (irq is registered from next snapshot).
- Status word: bit0 valid, bit1 overrun, bit2 timeout, bit3 busy (state != IDLE), bits15:4 = 0.
- Read handshake:
  - When rd_req = 1 and rd_ack = 0, in the next cycle rd_ack = 1 and rd_data = the selected word as of the request cycle.
  - rd_ack is a single-cycle pulse.
  - The processor drops rd_req after the ack; if rd_req is still high, a new ack follows 2 cycles after the previous one (one idle cycle).
  - rd_data holds its value until the next ack.
- Clear-on-read (CLEAR_ON_READ = 1):
  - An acked read of addr 0 clears snapshot[15:0]; addr 1 clears snapshot[29:16].
  - Addr 2 clears overrun, timeout and valid.
  - Addr 3 has no side effect.
  - If a clear and a CAPTURE hit the same cycle, CAPTURE wins: the new snapshot and status are kept.
- With CLEAR_ON_READ = 0, reads have no side effects.
- Unused rd_data bits read 0.

Test Plan:
- Reset then idle: all outputs 0; read addr 2 -> rd_data = 0x0000 one cycle after rd_req.
- Normal frame:
  - Stimulus: frame_start; 20 cycles later analyze_done with flags_in = 30'h2000_0005.
  - Response: analyze_enable high 1 cycle after frame_start until CAPTURE; irq = 1.
  - Reads: addr 0 -> 0x0005; addr 1 -> 0x2000; addr 3 -> 0x0001; addr 2 -> 0x0001.
- Clear-on-read: after the normal frame, read addr 0 then addr 1 -> irq falls after the second ack; re-read addr 0 -> 0x0000.
- Overrun: second frame_start 5 cycles into RUN -> ignored, only one analysis runs, status = 0x0003 after capture.
- Timeout: TIMEOUT_CYCLES = 16, no analyze_done -> analyze_enable drops after 16 cycles, status = 0x0004, snapshot unchanged, frame counter unchanged.
- Simultaneous events:
  - Stimulus: read-clear of addr 0 in the same cycle as CAPTURE of flags 0x0000_0003.
  - Response: snapshot = 0x3, irq stays 1, rd_data returns the old value.
  - Also: reset asserted mid-RUN -> all outputs 0 next cycle, status = 0.
